// File: rtl/mux_sel_pkg.sv
// Shared types and selector encoding for the 4:1 selector arbiter.
//   state_t  : arbiter FSM states
//   SEL_CHx  : selector codes expected by the downstream 4:1 data selector
//   enc_sel  : channel index -> selector code (bit-swapped index)
package mux_sel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b10;
  localparam logic [1:0] SEL_CH2 = 2'b01;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  // Downstream selector wires its select bits swapped relative to the index.
  function automatic logic [1:0] enc_sel(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'd0:    code = SEL_CH0;
      2'd1:    code = SEL_CH1;
      2'd2:    code = SEL_CH2;
      default: code = SEL_CH3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request searching upward from
// (ptr+1) mod 4.
//   req   in  4  request vector
//   ptr   in  2  last owner
//   valid out 1  any request present
//   idx   out 2  chosen channel (meaningful only when valid)
module rr_priority_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] w_base;
  logic [3:0] w_rot;
  logic [1:0] w_off;

  assign w_base = ptr + 2'd1;

  // Rotate so bit 0 is the highest-priority channel.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 4; i++) begin
      w_rot[i] = req[w_base + 2'(i)];
    end
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
  end

  // Un-rotate back to an absolute channel index.
  assign idx   = w_base + w_off;
  assign valid = |req;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 data selector.
// Holds a grant until done, request drop, or HOLD_MAX cycles elapse.
//   clk     in  1  rising-edge clock
//   rst     in  1  synchronous active-high reset
//   req     in  4  per-channel request
//   done    in  1  owner finished (used only while granted)
//   grant   out 4  registered one-hot grant, zero when idle
//   sel     out 2  registered selector code of the last grant
//   busy    out 1  high while a grant is held
//   timeout out 1  one-cycle pulse after a hold-limit-only release
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  state_t             r_state;
  logic [3:0]         r_grant;
  logic [1:0]         r_sel;
  logic               r_busy;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_ptr;

  state_t             w_state_nxt;
  logic [3:0]         w_grant_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_busy_nxt;
  logic               w_timeout_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         w_ptr_nxt;

  logic               w_pick_valid;
  logic [1:0]         w_pick_idx;
  logic               w_limit;
  logic               w_owner_req;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_limit     = (r_cnt == CNT_W'(HOLD_MAX - 1));
  assign w_owner_req = req[r_ptr];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= 4'b0000;
      r_sel     <= 2'b00;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= 2'd3;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_ptr_nxt     = r_ptr;

    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = GRANT;
          w_grant_nxt = 4'b0001 << w_pick_idx;
          w_sel_nxt   = enc_sel(w_pick_idx);
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = w_pick_idx;
        end
      end
      GRANT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (done || !w_owner_req || w_limit) begin
          w_state_nxt   = IDLE;
          w_grant_nxt   = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_cnt_nxt     = '0;
          // Only a pure hold-limit release is reported as a timeout.
          w_timeout_nxt = w_limit && !done && w_owner_req;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_fail;

  mux_sel_arbiter #(.HOLD_MAX(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if ({grant, sel, busy, timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL reset_state got g=%b s=%b b=%b t=%b exp g=0000 s=00 b=0 t=0", grant, sel, busy, timeout);
    end
  endtask

  task automatic test_single_grant();
    req = 4'b0100;
    step();
    n_checks++;
    if ({grant, sel, busy, timeout} !== 8'b0100_01_1_0) begin
      n_fail++;
      $display("FAIL single_grant got g=%b s=%b b=%b t=%b exp g=0100 s=01 b=1 t=0", grant, sel, busy, timeout);
    end
    req = 4'b0000;
    step();
    n_checks++;
    if ({grant, busy, timeout} !== 6'b0000_0_0) begin
      n_fail++;
      $display("FAIL single_release got g=%b b=%b t=%b exp g=0000 b=0 t=0", grant, busy, timeout);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    exp_g[0] = 4'b0001; exp_s[0] = 2'b00;
    exp_g[1] = 4'b0010; exp_s[1] = 2'b10;
    exp_g[2] = 4'b0100; exp_s[2] = 2'b01;
    exp_g[3] = 4'b1000; exp_s[3] = 2'b11;
    exp_g[4] = 4'b0001; exp_s[4] = 2'b00;
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (grant !== exp_g[k] || sel !== exp_s[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d got g=%b s=%b b=%b exp g=%b s=%b b=1", k, grant, sel, busy, exp_g[k], exp_s[k]);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      n_checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_release%0d got g=%b b=%b t=%b exp g=0000 b=0 t=0", k, grant, busy, timeout);
      end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    int busy_cycles;
    req = 4'b0010; done = 1'b0;
    step();
    busy_cycles = 0;
    for (int i = 0; i < 12 && busy === 1'b1; i++) begin
      busy_cycles++;
      if (timeout !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL to_early_pulse cycle %0d got t=%b exp t=0", i, timeout);
      end
      step();
    end
    n_checks++;
    if (busy_cycles != 8) begin
      n_fail++;
      $display("FAIL to_busy_len got %0d exp 8", busy_cycles);
    end
    n_checks++;
    if ({grant, busy, timeout} !== 6'b0000_0_1) begin
      n_fail++;
      $display("FAIL to_release got g=%b b=%b t=%b exp g=0000 b=0 t=1", grant, busy, timeout);
    end
    step();
    n_checks++;
    if ({grant, sel, busy, timeout} !== 8'b0010_10_1_0) begin
      n_fail++;
      $display("FAIL to_regrant got g=%b s=%b b=%b t=%b exp g=0010 s=10 b=1 t=0", grant, sel, busy, timeout);
    end
    done = 1'b1; step(); done = 1'b0; req = 4'b0000;
    step();
  endtask

  task automatic test_done_at_limit();
    req = 4'b0001; done = 1'b0;
    step();
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if (busy !== 1'b1 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL lim_still_busy got g=%b b=%b exp g=0001 b=1", grant, busy);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    n_checks++;
    if ({grant, busy, timeout} !== 6'b0000_0_0) begin
      n_fail++;
      $display("FAIL lim_done_release got g=%b b=%b t=%b exp g=0000 b=0 t=0", grant, busy, timeout);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_req_drop();
    req = 4'b1000; done = 1'b0;
    step();
    req = 4'b1001;
    step();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'b11) begin
      n_fail++;
      $display("FAIL drop_hold_busy got g=%b s=%b exp g=1000 s=11", grant, sel);
    end
    req = 4'b0001;
    step();
    n_checks++;
    if ({grant, busy, timeout} !== 6'b0000_0_0) begin
      n_fail++;
      $display("FAIL drop_release got g=%b b=%b t=%b exp g=0000 b=0 t=0", grant, busy, timeout);
    end
    step();
    n_checks++;
    if (grant !== 4'b0001 || sel !== 2'b00) begin
      n_fail++;
      $display("FAIL drop_next_grant got g=%b s=%b exp g=0001 s=00", grant, sel);
    end
    done = 1'b1; step(); done = 1'b0; req = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0100;
    step();
    step();
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL rmg_owner got g=%b exp g=0100", grant);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0101;
    n_checks++;
    if ({grant, sel, busy, timeout} !== 8'b0000_00_0_0) begin
      n_fail++;
      $display("FAIL rmg_reset got g=%b s=%b b=%b t=%b exp g=0000 s=00 b=0 t=0", grant, sel, busy, timeout);
    end
    step();
    n_checks++;
    if (grant !== 4'b0001 || sel !== 2'b00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rmg_ptr_reset got g=%b s=%b b=%b exp g=0001 s=00 b=1", grant, sel, busy);
    end
    done = 1'b1; step(); done = 1'b0; req = 4'b0000;
    step();
  endtask

  task automatic test_idle_hold();
    int bad;
    req = 4'b1000;
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      done = (i % 3 == 0);
      step();
      if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'b11 || timeout !== 1'b0) bad++;
    end
    done = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_hold got %0d bad cycles (last g=%b s=%b b=%b) exp 0 with s=11", bad, grant, sel, busy);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_timeout();
    test_done_at_limit();
    test_req_drop();
    test_reset_mid_grant();
    test_idle_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
